// File: rtl/rom_rd_arbiter_pkg.sv
`default_nettype none
// rom_arb_pkg: shared state encoding, requester IDs and default geometry for rom_rd_arbiter.
// Revision: 1.0
package rom_arb_pkg;

  localparam int DEF_AW      = 5;
  localparam int DEF_DW      = 4;
  localparam int DEF_ROM_LAT = 1;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rom_rd_arbiter_if.sv
`default_nettype none
// rom_rd_arbiter_if: client request/valid pairs plus the shared ROM port of rom_rd_arbiter.
// Revision: 1.0
interface rom_rd_arbiter_if #(
  parameter int AW = rom_arb_pkg::DEF_AW,
  parameter int DW = rom_arb_pkg::DEF_DW
) ();

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          vld0;
  logic          vld1;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;

  modport slave (
    input  req0, req1, addr0, addr1, rom_q,
    output vld0, vld1, rd_data, busy, rom_addr
  );

  modport master (
    output req0, req1, addr0, addr1, rom_q,
    input  vld0, vld1, rd_data, busy, rom_addr
  );

endinterface
`default_nettype wire

// File: rtl/rom_rd_arbiter_rr_arb2.sv
`default_nettype none
// rr_arb2: combinational two-way grant selection; ROM_ARB_FIXED_PRIO_EN makes requester 0 win ties.
// Revision: 1.0
module rr_arb2
  import rom_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic gnt_valid,
  output logic gnt_id
);

`ifdef ROM_ARB_FIXED_PRIO_EN
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = req0 ? REQ0 : REQ1;
  end
`else
  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = req0 ? REQ0 : REQ1;
    // On a tie, the requester that did not win last time goes next.
    if (req0 && req1) begin
      gnt_id = ~last_gnt;
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/rom_rd_arbiter.sv
`default_nettype none
// rom_rd_arbiter: shares one synchronous ROM between two request/valid readers (round-robin,
// or fixed priority with ROM_ARB_FIXED_PRIO_EN). Revision: 1.0
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic            sclk,
  input  logic            nrst,
  rom_rd_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(ROM_LAT + 1);
  localparam logic [CW-1:0] LAT_END = CW'(ROM_LAT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_gnt;
  logic          gnt_id;
  logic          sel_valid;
  logic          sel_id;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] q_word;

  rr_arb2 u_arb (
    .req0      (bus.req0),
    .req1      (bus.req1),
    .last_gnt  (last_gnt),
    .gnt_valid (sel_valid),
    .gnt_id    (sel_id)
  );

  assign sel_addr = sel_id ? bus.addr1 : bus.addr0;
  assign q_word   = bus.rom_q;
  assign bus.busy = (state == WAIT);

  always_ff @(posedge sclk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      cnt          <= '0;
      last_gnt     <= REQ1;
      gnt_id       <= REQ0;
      bus.rom_addr <= '0;
      bus.rd_data  <= '0;
      bus.vld0     <= 1'b0;
      bus.vld1     <= 1'b0;
    end else begin
      bus.vld0 <= 1'b0;
      bus.vld1 <= 1'b0;
      case (state)
        IDLE: begin
          if (sel_valid) begin
            bus.rom_addr <= sel_addr;
            gnt_id       <= sel_id;
            last_gnt     <= sel_id;
            cnt          <= '0;
            state        <= WAIT;
          end
        end
        WAIT: begin
          // The read completes even if the requester drops req mid-flight.
          if (cnt == LAT_END) begin
            bus.rd_data <= q_word;
            bus.vld0    <= (gnt_id == REQ0);
            bus.vld1    <= (gnt_id == REQ1);
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/rom_rd_arbiter.md
# rom_rd_arbiter

Read arbiter that shares one single-port synchronous ROM (AW-bit address, DW-bit data, registered address input) between two independent requesters. Sits between the ROM instance and client logic such as the address-traversal/LED display path and a second reader. Each requester gets a request/valid handshake and never touches the ROM ports directly. Arbitration is round-robin by default, with fixed priority selectable at compile time.

## Interface
- AW, 5, ROM address width
- DW, 4, ROM data width
- ROM_LAT, 1, ROM edges from the address-sampling edge until q is stable (1 = unregistered q, 2 = registered q); legal range 1..3
- sclk  in  1  system clock; all logic on the rising edge
- nrst  in  1  reset, asynchronous assert, active-low
- req0 / req1  in  1  read request; held high until the matching valid
- addr0 / addr1  in  AW  read address; stable while the matching req is high
- vld0 / vld1  out  1  one-cycle pulse; data for that requester is on rd_data
- rd_data  out  DW  captured ROM word, shared by both requesters; holds its value between reads
- busy  out  1  high while a transaction is in flight (state is not IDLE)
- rom_addr  out  AW  registered address to the ROM
- rom_q  in  DW  ROM output

## Operation
- Reset values:
  - rom_addr = 0, rd_data = 0
  - vld0 = vld1 = 0, busy = 0
  - state = IDLE, wait counter = 0, last_gnt = 1, so requester 0 wins the first tie.
- States:
  - IDLE: if no req, stay. If only one req is high, grant it. If both are high, grant the requester that is not last_gnt. On the grant edge: load rom_addr from the granted addr, record gnt_id, update last_gnt, clear the counter, go to WAIT.
  - WAIT: the counter increments each edge. When it reaches ROM_LAT, the next edge captures rom_q into rd_data, pulses vld[gnt_id] for one cycle, and returns to IDLE.
- A requester still asserting req in the cycle its vld is high is treated as issuing a new request; it competes at the following IDLE edge.
- req dropping during WAIT (a protocol violation) does not abort the transaction. The read completes and vld is still pulsed.
- Only one vld is high in any cycle. busy = (state != IDLE).
- The counter is sized as clog2(ROM_LAT+1) bits and never wraps.
- rom_addr holds its last value in IDLE; there is no spurious address change.

## Timing
- Grant edge E:
  - rom_addr is valid after E.
  - The ROM samples the address at E+1.
  - rd_data is captured at E+1+ROM_LAT.
  - vld is high for the cycle following that edge.
- Latency from req first sampled high in IDLE to vld is ROM_LAT+2 cycles.
- The FSM re-enters IDLE on the capture edge. The next grant happens at the following edge, giving a peak throughput of one read per ROM_LAT+2 cycles.
- Both requesting continuously: grants alternate 0,1,0,1… with no starvation.
- nrst asserted mid-transaction: outputs go to reset values immediately, the in-flight read is dropped, and no vld is issued.

## Configuration
- ROM_ARB_FIXED_PRIO_EN defined: requester 0 always wins a tie and last_gnt is ignored; requester 1 can starve under continuous req0.
- ROM_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Structure
- Package rom_arb_pkg holds:
  - state encoding constants: IDLE = 1'b0, WAIT = 1'b1
  - default AW/DW/ROM_LAT values
  - requester ID constants REQ0 = 0, REQ1 = 1
- One sub-module, rr_arb2: combinational 2-way grant selection from (req0, req1, last_gnt), containing the compile-time fixed-priority switch. The FSM, counter and datapath stay in rom_rd_arbiter.

## Test plan
All scenarios use a bench ROM model with rom_q = addr[3:0] ^ 4'hA, ROM_LAT = 1 unless noted.
- Single read: req0 = 1, addr0 = 5'd3, from IDLE → vld0 high exactly 3 cycles after req0 is first sampled, rd_data = 4'h9, vld1 never high.
- Tie after reset: req0 = req1 = 1 at the same edge, addr0 = 1, addr1 = 2 → vld0 (rd_data = 4'hB) first, then vld1 (rd_data = 4'h8) 3 cycles later. With ROM_ARB_FIXED_PRIO_EN and req0 held high, vld1 never appears.
- Continuous contention over 8 transactions → grant order 0,1,0,1,0,1,0,1; vld pulses spaced 3 cycles apart; busy low only for the single IDLE cycle between transactions.
- ROM_LAT = 2, req1 = 1, addr1 = 5'd31 → vld1 exactly 4 cycles after the first sample, rd_data = 4'h5.
- nrst pulsed low during WAIT → rom_addr, rd_data, vld0, vld1 and busy all 0 immediately. After release with no req, no vld appears for 10 cycles.
- req0 dropped during WAIT → vld0 still pulses once with the correct data; the FSM then returns to IDLE and stays there.
